vga_scan_timing: RTL and testbench

//  Raster scan generator and output stage for the score display. Counts pixel/line

---
 rtl/vga_scan_timing.sv | 180 ++++++++++++++++++
 tb/tb_vga_scan_timing.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// Raster scan generator and output stage: pixel/line counters, x/y to the colour stage,
// timing delay line matched to the colour pipeline, registered VGA pins and a frame tick.
module vga_scan_timing #(
   parameter int H_ACTIVE           = 640,
   parameter int H_FP               = 16,
   parameter int H_SYNC             = 96,
   parameter int H_BP               = 48,
   parameter int V_ACTIVE           = 480,
   parameter int V_FP               = 10,
   parameter int V_SYNC             = 2,
   parameter int V_BP               = 33,
   parameter int SCREEN_WIDTH_BITS  = 10,
   parameter int SCREEN_HEIGHT_BITS = 10,
   parameter bit SYNC_ACTIVE        = 1'b0,
   parameter int PIPE_DELAY         = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pix_en,
   output logic [SCREEN_WIDTH_BITS-1:0]  x,
   output logic [SCREEN_HEIGHT_BITS-1:0] y,
   input  logic [7:0]                    in_r,
   input  logic [7:0]                    in_g,
   input  logic [7:0]                    in_b,
   output logic [7:0]                    vga_r,
   output logic [7:0]                    vga_g,
   output logic [7:0]                    vga_b,
   output logic                          vga_hs,
   output logic                          vga_vs,
   output logic                          vga_de,
   output logic                          frame_tick
);

   localparam int HW = SCREEN_WIDTH_BITS;
   localparam int VW = SCREEN_HEIGHT_BITS;

   localparam logic [HW-1:0] H_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [HW-1:0] H_VIS     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_ST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_EN = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [VW-1:0] V_VIS     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_VIS_END = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] V_SYNC_ST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_EN = VW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ON  = SYNC_ACTIVE;
   localparam logic SYNC_OFF = ~SYNC_ACTIVE;

   logic [HW-1:0] hc_q, hc_d;
   logic [VW-1:0] vc_q, vc_d;
   logic          line_end_s;
   logic          de_raw_s, hs_raw_s, vs_raw_s;
   logic          de_dly_s, hs_dly_s, vs_dly_s;
   logic          tick_d;

   logic [7:0]    vga_r_q, vga_g_q, vga_b_q;
   logic          vga_hs_q, vga_vs_q, vga_de_q, frame_tick_q;

   // Next-state for the horizontal and vertical position counters.
   always_comb begin
      hc_d       = hc_q;
      vc_d       = vc_q;
      line_end_s = (hc_q == H_LAST);
      if (pix_en) begin
         if (line_end_s) begin
            hc_d = {HW{1'b0}};
            if (vc_q == V_LAST) begin
               vc_d = {VW{1'b0}};
            end else begin
               vc_d = vc_q + VW'(1);
            end
         end else begin
            hc_d = hc_q + HW'(1);
            vc_d = vc_q;
         end
      end else begin
         hc_d = hc_q;
         vc_d = vc_q;
      end
   end

   // Position counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc_q <= {HW{1'b0}};
         vc_q <= {VW{1'b0}};
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // Undelayed timing flags and frame-tick condition for the current position.
   always_comb begin
      de_raw_s = (hc_q < H_VIS) && (vc_q < V_VIS);
      hs_raw_s = (hc_q >= H_SYNC_ST) && (hc_q < H_SYNC_EN);
      vs_raw_s = (vc_q >= V_SYNC_ST) && (vc_q < V_SYNC_EN);
      tick_d   = pix_en && line_end_s && (vc_q == V_VIS_END);
   end

   // Timing flags travel alongside the colour stage's own pipeline.
   generate
      if (PIPE_DELAY > 0) begin : g_dly
         logic [PIPE_DELAY-1:0] de_sr_q, hs_sr_q, vs_sr_q;

         // Delay line shift registers, advanced once per pixel slot.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               de_sr_q <= {PIPE_DELAY{1'b0}};
               hs_sr_q <= {PIPE_DELAY{1'b0}};
               vs_sr_q <= {PIPE_DELAY{1'b0}};
            end else if (pix_en) begin
               de_sr_q[0] <= de_raw_s;
               hs_sr_q[0] <= hs_raw_s;
               vs_sr_q[0] <= vs_raw_s;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  de_sr_q[i] <= de_sr_q[i-1];
                  hs_sr_q[i] <= hs_sr_q[i-1];
                  vs_sr_q[i] <= vs_sr_q[i-1];
               end
            end else begin
               de_sr_q <= de_sr_q;
               hs_sr_q <= hs_sr_q;
               vs_sr_q <= vs_sr_q;
            end
         end

         assign de_dly_s = de_sr_q[PIPE_DELAY-1];
         assign hs_dly_s = hs_sr_q[PIPE_DELAY-1];
         assign vs_dly_s = vs_sr_q[PIPE_DELAY-1];
      end else begin : g_nodly
         assign de_dly_s = de_raw_s;
         assign hs_dly_s = hs_raw_s;
         assign vs_dly_s = vs_raw_s;
      end
   endgenerate

   // Registered VGA pins; colour is forced to black outside the visible area.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_r_q  <= 8'h00;
         vga_g_q  <= 8'h00;
         vga_b_q  <= 8'h00;
         vga_de_q <= 1'b0;
         vga_hs_q <= SYNC_OFF;
         vga_vs_q <= SYNC_OFF;
      end else if (pix_en) begin
         vga_de_q <= de_dly_s;
         vga_hs_q <= hs_dly_s ? SYNC_ON : SYNC_OFF;
         vga_vs_q <= vs_dly_s ? SYNC_ON : SYNC_OFF;
         {vga_r_q, vga_g_q, vga_b_q} <= de_dly_s ? {in_r, in_g, in_b} : 24'h000000;
      end else begin
         vga_de_q <= vga_de_q;
         vga_hs_q <= vga_hs_q;
         vga_vs_q <= vga_vs_q;
         {vga_r_q, vga_g_q, vga_b_q} <= {vga_r_q, vga_g_q, vga_b_q};
      end
   end

   // Frame tick: single clk pulse, not gated by the hold behaviour of the pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= tick_d;
      end
   end

   assign x          = hc_q;
   assign y          = vc_q;
   assign vga_r      = vga_r_q;
   assign vga_g      = vga_g_q;
   assign vga_b      = vga_b_q;
   assign vga_hs     = vga_hs_q;
   assign vga_vs     = vga_vs_q;
   assign vga_de     = vga_de_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: two reduced-size instances (no delay/active-low sync and
// 2-slot delay/active-high sync) compared every cycle with a pixel-index reference model.
module tb_vga_scan_timing;

   localparam int HA = 16, HFP = 4, HSY = 6, HBP = 6;
   localparam int VA = 12, VFP = 2, VSY = 2, VBP = 4;
   localparam int HT = HA + HFP + HSY + HBP;   // 32
   localparam int VT = VA + VFP + VSY + VBP;   // 20
   localparam int FT = HT * VT;                // 640
   localparam int WB = 6, HB = 5;

   logic clk, rst, pix_en;
   logic [7:0] in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
   logic [WB-1:0] x0, x1;
   logic [HB-1:0] y0, y1;
   logic [7:0] r0, g0, b0, r1, g1, b1;
   logic hs0, vs0, de0, tk0, hs1, vs1, de1, tk1;
   logic [WB-1:0] d1x, d2x;
   logic [HB-1:0] d1y, d2y;

   int n_checks = 0;
   int n_err    = 0;
   int k;
   int de_tot = 0, hs_low_tot = 0, vs_low_tot = 0, tick_tot = 0;

   vga_scan_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SCREEN_WIDTH_BITS(WB), .SCREEN_HEIGHT_BITS(HB),
      .SYNC_ACTIVE(1'b0), .PIPE_DELAY(0)
   ) dut0 (
      .clk(clk), .rst(rst), .pix_en(pix_en), .x(x0), .y(y0),
      .in_r(in_r0), .in_g(in_g0), .in_b(in_b0),
      .vga_r(r0), .vga_g(g0), .vga_b(b0),
      .vga_hs(hs0), .vga_vs(vs0), .vga_de(de0), .frame_tick(tk0)
   );

   vga_scan_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SCREEN_WIDTH_BITS(WB), .SCREEN_HEIGHT_BITS(HB),
      .SYNC_ACTIVE(1'b1), .PIPE_DELAY(2)
   ) dut1 (
      .clk(clk), .rst(rst), .pix_en(pix_en), .x(x1), .y(y1),
      .in_r(in_r1), .in_g(in_g1), .in_b(in_b1),
      .vga_r(r1), .vga_g(g1), .vga_b(b1),
      .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1), .frame_tick(tk1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in colour stage for dut1: two pixel slots of latency from x/y.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         d1x <= '0; d2x <= '0; d1y <= '0; d2y <= '0;
      end else if (pix_en) begin
         d1x <= x1; d1y <= y1; d2x <= d1x; d2y <= d1y;
      end
   end
   assign in_r1 = 8'(d2x);
   assign in_g1 = 8'(d2y);
   assign in_b1 = ~(8'(d2x));

   function automatic int hpos(input int p);
      return p % HT;
   endfunction
   function automatic int vpos(input int p);
      return (p / HT) % VT;
   endfunction
   function automatic bit m_de(input int p);
      return (p >= 0) && (hpos(p) < HA) && (vpos(p) < VA);
   endfunction
   function automatic bit m_hs(input int p);
      return (p >= 0) && (hpos(p) >= HA + HFP) && (hpos(p) < HA + HFP + HSY);
   endfunction
   function automatic bit m_vs(input int p);
      return (p >= 0) && (vpos(p) >= VA + VFP) && (vpos(p) < VA + VFP + VSY);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: k counts enabled edges since reset; output shows pixel k-1-delay.
   initial begin
      logic en_s, rst_s, tick_exp;
      logic [23:0] col_s, last_col0, exp1;
      int p0, p1;
      k = 0;
      last_col0 = 24'h0;
      forever begin
         @(posedge clk);
         en_s  = pix_en;
         rst_s = rst;
         col_s = {in_r0, in_g0, in_b0};
         #1;
         tick_exp = 1'b0;
         if (rst_s) begin
            k = 0;
         end else if (en_s) begin
            tick_exp  = ((k % FT) == VA * HT - 1);
            k++;
            last_col0 = col_s;
         end
         p0 = k - 1;
         p1 = k - 3;
         check("x0", 32'(x0), 32'(hpos(k)));
         check("y0", 32'(y0), 32'(vpos(k)));
         check("x1", 32'(x1), 32'(hpos(k)));
         check("y1", 32'(y1), 32'(vpos(k)));
         check("de0", 32'(de0), 32'(m_de(p0)));
         check("hs0", 32'(hs0), 32'(!m_hs(p0)));
         check("vs0", 32'(vs0), 32'(!m_vs(p0)));
         check("rgb0", 32'({r0, g0, b0}), 32'(m_de(p0) ? last_col0 : 24'h0));
         check("tick0", 32'(tk0), 32'(tick_exp));
         exp1 = m_de(p1) ? {8'(hpos(p1)), 8'(vpos(p1)), ~(8'(hpos(p1)))} : 24'h0;
         check("de1", 32'(de1), 32'(m_de(p1)));
         check("hs1", 32'(hs1), 32'(m_hs(p1)));
         check("vs1", 32'(vs1), 32'(m_vs(p1)));
         check("rgb1", 32'({r1, g1, b1}), 32'(exp1));
         check("tick1", 32'(tk1), 32'(tick_exp));
         de_tot     += int'(de0);
         hs_low_tot += int'(!hs0);
         vs_low_tot += int'(!vs0);
         tick_tot   += int'(tk0);
      end
   end

   task automatic rand_colour();
      in_r0 = 8'($urandom_range(0, 255));
      in_g0 = 8'($urandom_range(0, 255));
      in_b0 = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int s_de, s_hs, s_vs, s_tk;
      bit found;
      rst = 1'b1;
      pix_en = 1'b0;
      rand_colour();
      repeat (3) @(negedge clk);
      check("rst_x", 32'(x0), 32'd0);
      check("rst_hs_low_pol", 32'(hs0), 32'd1);
      check("rst_hs_high_pol", 32'(hs1), 32'd0);
      check("rst_rgb", 32'({r0, g0, b0}), 32'd0);
      rst = 1'b0;

      // Two full frames with one pixel per clk.
      s_de = de_tot; s_hs = hs_low_tot; s_vs = vs_low_tot; s_tk = tick_tot;
      for (int i = 0; i < 2 * FT; i++) begin
         pix_en = 1'b1;
         rand_colour();
         @(negedge clk);
      end
      pix_en = 1'b0;
      check("de_count_2frames", 32'(de_tot - s_de), 32'd384);
      check("hs_low_2frames", 32'(hs_low_tot - s_hs), 32'd240);
      check("vs_low_2frames", 32'(vs_low_tot - s_vs), 32'd128);
      check("ticks_2frames", 32'(tick_tot - s_tk), 32'd2);

      // Sparse random enable.
      for (int i = 0; i < 3000; i++) begin
         pix_en = ($urandom_range(0, 3) == 0);
         rand_colour();
         @(negedge clk);
      end

      // Enable on every 4th clk for two frames from a fresh reset.
      rst = 1'b1; pix_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      s_tk = tick_tot;
      for (int i = 0; i < 4 * 2 * FT; i++) begin
         pix_en = ((i % 4) == 3);
         rand_colour();
         @(negedge clk);
      end
      check("ticks_div4", 32'(tick_tot - s_tk), 32'd2);

      // First white pixel one slot after x=0,y=0, then position after 33 slots.
      rst = 1'b1; pix_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      in_r0 = 8'hFF; in_g0 = 8'hFF; in_b0 = 8'hFF;
      pix_en = 1'b1;
      @(negedge clk);
      check("first_white", 32'({r0, g0, b0}), 32'h00FFFFFF);
      check("first_de1_late", 32'(de1), 32'd0);
      repeat (32) @(negedge clk);
      check("pos33_x", 32'(x0), 32'd1);
      check("pos33_y", 32'(y0), 32'd1);

      // Asynchronous reset in the middle of a visible line.
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         rand_colour();
         if (x0 == WB'(10) && y0 == HB'(7)) found = 1'b1;
         else @(negedge clk);
      end
      check("reach_midline", 32'(found), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_x", 32'(x0), 32'd0);
      check("async_y", 32'(y0), 32'd0);
      check("async_de", 32'(de0), 32'd0);
      check("async_hs0", 32'(hs0), 32'd1);
      check("async_hs1", 32'(hs1), 32'd0);
      check("async_rgb1", 32'({r1, g1, b1}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_x", 32'(x0), 32'd0);
      check("post_rst_y", 32'(y0), 32'd0);
      @(negedge clk);

      // Random enable with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         pix_en = $urandom_range(0, 1) == 1;
         rst = ($urandom_range(0, 149) == 0);
         rand_colour();
         @(negedge clk);
      end
      rst = 1'b0;
      pix_en = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
